act_unit_vec: RTL and testbench

- Parametrised, multi-lane successor to the single-lane reLU block.
- Applies one of four activation functions to LANES signed DW-bit values per beat:
  - bypass
  - ReLU
  - leaky ReLU (arithmetic shift)
  - clipped ReLU
- Uses a 2-stage valid/ready pipeline with full backpressure.
- Sits between the MAC/accumulator array and the next layer's input buffer.
- Counts completed output beats for the layer sequencer.

---
 rtl/act_unit_vec.sv | 135 +++++++++++++
 tb/tb_act_unit_vec.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/act_unit_vec.sv
// Multi-lane activation unit: bypass / ReLU / leaky / clip per lane, behind a
// two-stage valid/ready pipeline, with a running count of delivered beats.
module act_unit_vec #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                  CLKEXT,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [LANES*DW-1:0]   DATA_IN,
  input  logic                  EN_ACT,
  input  logic [1:0]            MODE,
  input  logic [3:0]            LEAK_SHIFT,
  input  logic [DW-1:0]         CLIP_MAX,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [LANES*DW-1:0]   ACT_OUT,
  output logic [CNT_W-1:0]      BEAT_CNT
);

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_RELU   = 2'b01;
  localparam logic [1:0] MODE_LEAKY  = 2'b10;
  localparam logic [1:0] MODE_CLIP   = 2'b11;

  logic                r_s1_valid;
  logic [LANES*DW-1:0] r_s1_data;
  logic                r_s1_en;
  logic [1:0]          r_s1_mode;
  logic [3:0]          r_s1_shift;
  logic [DW-1:0]       r_s1_clip;

  logic                r_s2_valid;
  logic [LANES*DW-1:0] r_s2_data;
  logic [CNT_W-1:0]    r_beat_cnt;

  logic                w_s2_adv;
  logic                w_s1_adv;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic [LANES*DW-1:0] w_result;

  function automatic logic [DW-1:0] act_lane(
    input logic signed [DW-1:0] x,
    input logic                 en,
    input logic [1:0]           md,
    input logic [3:0]           sh,
    input logic signed [DW-1:0] cm
  );
    logic signed [DW-1:0] c;
    logic [DW-1:0]        y;
    // Negative clip ceiling collapses to zero so clip never passes negatives.
    c = cm[DW-1] ? '0 : cm;
    y = x;
    if (!en) begin
      y = '0;
    end else begin
      case (md)
        MODE_BYPASS: y = x;
        MODE_RELU:   y = x[DW-1] ? '0 : x;
        MODE_LEAKY: begin
          if (!x[DW-1])
            y = x;
          else if ({28'd0, sh} >= 32'(DW))
            y = '1;
          else
            y = x >>> sh;
        end
        MODE_CLIP:   y = x[DW-1] ? '0 : ((x > c) ? c : x);
        default:     y = x;
      endcase
    end
    return y;
  endfunction

  assign w_s2_adv   = !r_s2_valid | OUT_READY;
  assign w_s1_adv   = !r_s1_valid | w_s2_adv;
  assign IN_READY   = w_s1_adv & !RST;
  assign w_in_xfer  = IN_VALID & IN_READY;
  assign w_out_xfer = r_s2_valid & OUT_READY;

  always_comb begin
    w_result = '0;
    for (int i = 0; i < LANES; i++) begin
      w_result[i*DW +: DW] = act_lane($signed(r_s1_data[i*DW +: DW]), r_s1_en,
                                      r_s1_mode, r_s1_shift, $signed(r_s1_clip));
    end
  end

  // Config is captured alongside the data so later changes miss in-flight beats.
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_en    <= 1'b0;
      r_s1_mode  <= MODE_BYPASS;
      r_s1_shift <= '0;
      r_s1_clip  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_in_xfer;
      if (w_in_xfer) begin
        r_s1_data  <= DATA_IN;
        r_s1_en    <= EN_ACT;
        r_s1_mode  <= MODE;
        r_s1_shift <= LEAK_SHIFT;
        r_s1_clip  <= CLIP_MAX;
      end
    end
  end

  // Result register only loads real beats, so ACT_OUT holds across bubbles.
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_data <= w_result;
    end
  end

  always_ff @(posedge CLKEXT) begin
    if (RST)
      r_beat_cnt <= '0;
    else if (w_out_xfer)
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
  end

  assign OUT_VALID = r_s2_valid;
  assign ACT_OUT   = r_s2_data;
  assign BEAT_CNT  = r_beat_cnt;

endmodule

// File: tb/tb_act_unit_vec.sv
// Bench for act_unit_vec: directed vector table, backpressure/reset/wrap
// sequences, and a randomized phase scored against an arithmetic model.
module tb_act_unit_vec;
  localparam int DW = 16;
  localparam int LANES = 4;

  logic clk, rst, in_valid, in_ready, en_act, out_valid, out_ready;
  logic [LANES*DW-1:0] din, act_out;
  logic [1:0] mode;
  logic [3:0] leak_shift;
  logic [DW-1:0] clip_max;
  logic [15:0] beat_cnt;
  logic in_ready4, out_valid4;
  logic [LANES*DW-1:0] act4;
  logic [3:0] cnt4;

  int total = 0;
  int bad = 0;

  act_unit_vec #(.DW(DW), .LANES(LANES), .CNT_W(16)) u_dut (
    .CLKEXT(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .DATA_IN(din), .EN_ACT(en_act), .MODE(mode), .LEAK_SHIFT(leak_shift),
    .CLIP_MAX(clip_max), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .ACT_OUT(act_out), .BEAT_CNT(beat_cnt));

  act_unit_vec #(.DW(DW), .LANES(LANES), .CNT_W(4)) u_dut4 (
    .CLKEXT(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready4),
    .DATA_IN(din), .EN_ACT(en_act), .MODE(mode), .LEAK_SHIFT(leak_shift),
    .CLIP_MAX(clip_max), .OUT_VALID(out_valid4), .OUT_READY(out_ready),
    .ACT_OUT(act4), .BEAT_CNT(cnt4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: each lane computed with plain integer arithmetic.
  function automatic logic [LANES*DW-1:0] ref_beat(input logic [LANES*DW-1:0] d,
      input logic en, input logic [1:0] md, input logic [3:0] sh, input logic [DW-1:0] cm);
    logic [LANES*DW-1:0] r;
    int x, y, c, p;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x = int'($signed(d[i*DW +: DW]));
      c = int'($signed(cm));
      if (c < 0) c = 0;
      y = x;
      if (!en) y = 0;
      else if (md == 2'd1) y = (x < 0) ? 0 : x;
      else if (md == 2'd2) begin
        if (x < 0) begin
          if (int'(sh) >= DW) y = -1;
          else begin
            p = 1 << sh;
            y = x / p;
            if (y * p != x) y = y - 1;
          end
        end
      end else if (md == 2'd3) y = (x < 0) ? 0 : ((x > c) ? c : x);
      r[i*DW +: DW] = y[DW-1:0];
    end
    return r;
  endfunction

  logic [LANES*DW-1:0] q[$];
  logic [LANES*DW-1:0] prev_act, exp_w;
  int m_cnt = 0;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = 0;
      prev_stall = 1'b0;
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    end else begin
      check("beat_cnt", {48'd0, beat_cnt}, 64'(m_cnt % 65536));
      check("beat_cnt4", {60'd0, cnt4}, 64'(m_cnt % 16));
      check("twin_match", {act4, in_ready4, out_valid4}, {act_out, in_ready, out_valid});
      if (prev_stall) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_hold", act_out, prev_act);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_beat", act_out, 64'hDEAD);
        else begin
          exp_w = q.pop_front();
          check("act_out", act_out, exp_w);
        end
        m_cnt++;
      end
      if (in_valid && in_ready)
        q.push_back(ref_beat(din, en_act, mode, leak_shift, clip_max));
      prev_stall = out_valid && !out_ready;
      prev_act = act_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string               name;
    logic [LANES*DW-1:0] d;
    logic                en;
    logic [1:0]          md;
    logic [3:0]          sh;
    logic [DW-1:0]       cm;
    logic [LANES*DW-1:0] exp;
  } vec_t;

  vec_t vt[7];
  logic [LANES*DW-1:0] base, held;
  int nxt, n_out, sent;
  logic saw_block;

  initial begin
    base = {16'd7, 16'h8000, 16'hFFFF, 16'd1234};
    vt[0] = '{"bypass", base, 1'b1, 2'd0, 4'd0, 16'd0, base};
    vt[1] = '{"relu",   base, 1'b1, 2'd1, 4'd0, 16'd0, {16'd7, 16'h0, 16'h0, 16'd1234}};
    vt[2] = '{"leaky2", base, 1'b1, 2'd2, 4'd2, 16'd0, {16'd7, 16'hE000, 16'hFFFF, 16'd1234}};
    vt[3] = '{"clip100", base, 1'b1, 2'd3, 4'd0, 16'd100, {16'd7, 16'h0, 16'h0, 16'd100}};
    vt[4] = '{"en_off", {4{16'd5678}}, 1'b0, 2'd0, 4'd0, 16'd0, 64'd0};
    vt[5] = '{"clip_neg", base, 1'b1, 2'd3, 4'd0, 16'hFFF0, 64'd0};
    vt[6] = '{"leaky15", base, 1'b1, 2'd2, 4'd15, 16'd0, {16'd7, 16'hFFFF, 16'hFFFF, 16'd1234}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din = '0;
    en_act = 1'b1; mode = 2'd0; leak_shift = 4'd0; clip_max = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_act_out", act_out, 64'd0);
    check("rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {63'd0, in_ready}, 64'd1);
    tick();

    for (int i = 0; i < 7; i++) begin
      din = vt[i].d; en_act = vt[i].en; mode = vt[i].md;
      leak_shift = vt[i].sh; clip_max = vt[i].cm; in_valid = 1'b1;
      @(negedge clk);
      check({vt[i].name, "_ready"}, {63'd0, in_ready}, 64'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check({vt[i].name, "_early"}, {63'd0, out_valid}, 64'd0);
      tick();
      @(negedge clk);
      check({vt[i].name, "_valid"}, {63'd0, out_valid}, 64'd1);
      check(vt[i].name, act_out, vt[i].exp);
      tick();
    end

    // Config isolation: mode change right behind an accepted beat.
    en_act = 1'b1; din = {48'd0, 16'hFFFD}; mode = 2'd1; in_valid = 1'b1;
    tick();
    mode = 2'd0;
    tick();
    in_valid = 1'b0; mode = 2'd1;
    @(negedge clk);
    check("iso_first", act_out, 64'd0);
    tick();
    @(negedge clk);
    check("iso_second", act_out, {48'd0, 16'hFFFD});
    tick(); tick();

    // Backpressure: six beats, sink stalled for cycles 3..6.
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 2'd0; en_act = 1'b1;
    nxt = 1; n_out = 0; saw_block = 1'b0; held = '0;
    for (int c = 0; c < 40 && n_out < 6; c++) begin
      in_valid = (nxt <= 6);
      din = {4{16'(nxt)}};
      out_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (c == 3) held = act_out;
      if (c == 6) check("bp_hold", act_out, held);
      if (out_valid && out_ready) begin
        check("bp_order", act_out, {4{16'(n_out + 1)}});
        n_out++;
      end
      if (in_valid && in_ready) nxt++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_all_out", 64'(n_out), 64'd6);
    check("bp_blocked", {63'd0, saw_block}, 64'd1);
    @(negedge clk);
    check("bp_cnt", {48'd0, beat_cnt}, 64'd6);
    tick();

    // Mid-stream reset with two beats in flight.
    out_ready = 1'b0; in_valid = 1'b1; din = {4{16'd42}};
    tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mrst_ready", {63'd0, in_ready}, 64'd0);
    tick();
    @(negedge clk);
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_act", act_out, 64'd0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("mrst_no_stale", {63'd0, out_valid}, 64'd0);
      tick();
    end

    // 17 beats: 4-bit counter wraps to 1.
    sent = 0; in_valid = 1'b1; din = {4{16'd9}};
    for (int c = 0; c < 40 && sent < 17; c++) begin
      @(negedge clk);
      if (in_ready) sent++;
      tick();
      if (sent == 17) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    check("wrap_cnt4", {60'd0, cnt4}, 64'd1);
    check("wrap_cnt16", {48'd0, beat_cnt}, 64'd17);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < LANES; l++)
        din[l*DW +: DW] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3) - 2) : 16'($urandom);
      en_act = ($urandom_range(0, 7) != 0);
      mode = 2'($urandom);
      leak_shift = 4'($urandom);
      clip_max = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3000)) : 16'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) tick();
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
